rtc_timekeeper: RTL

//  Parametrised successor to the basic seconds/minutes/hours clock. It divides clk into a
//  one-second tick and keeps time internally in 24h form. It also provides a run enable,
//  a synchronous time load, 12h/24h display mode and a sticky daily alarm.

---
 rtl/rtc_timekeeper_pkg.sv | 61 ++++++
 rtl/rtc_prescaler.sv | 30 +++
 rtl/rtc_timekeeper.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rtc_timekeeper_pkg.sv
// rtl/rtc_timekeeper_pkg.sv - field widths, limits and time helpers for the RTC timekeeper
package rtc_timekeeper_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [HOUR_W-1:0] NOON     = 5'd12;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
    } rtc_time_t;

    function automatic logic time_valid(
        input logic [HOUR_W-1:0] h,
        input logic [MIN_W-1:0]  m,
        input logic [SEC_W-1:0]  s
    );
        return (h <= HOUR_MAX) && (m <= MIN_MAX) && (s <= SEC_MAX);
    endfunction

    // One-second advance with the full sec -> min -> hour -> midnight carry chain.
    function automatic rtc_time_t time_inc(input rtc_time_t t);
        rtc_time_t n;
        n = t;
        if (t.second == SEC_MAX) begin
            n.second = '0;
            if (t.minute == MIN_MAX) begin
                n.minute = '0;
                n.hour   = (t.hour == HOUR_MAX) ? '0 : t.hour + HOUR_W'(1);
            end else begin
                n.minute = t.minute + MIN_W'(1);
            end
        end else begin
            n.second = t.second + SEC_W'(1);
        end
        return n;
    endfunction

    function automatic logic [HOUR_W-1:0] display_hour(
        input logic [HOUR_W-1:0] h,
        input logic              mode_12h
    );
        if (!mode_12h) begin
            return h;
        end
        if (h == '0) begin
            return NOON;
        end
        if (h > NOON) begin
            return h - NOON;
        end
        return h;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// rtl/rtc_prescaler.sv - divides clk into a one-cycle second tick while enabled
module rtc_prescaler #(
    parameter int TICKS_PER_SEC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    // clr wins over counting so a time load restarts a full second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// rtl/rtc_timekeeper.sv - 24h timekeeper with time load, 12h/24h display and sticky daily alarm
module rtc_timekeeper
    import rtc_timekeeper_pkg::*;
#(
    parameter int TICKS_PER_SEC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        mode_12h,
    input  logic        set_valid,
    input  logic [4:0]  set_hours,
    input  logic [5:0]  set_minutes,
    input  logic [5:0]  set_seconds,
    input  logic        alarm_wr,
    input  logic [4:0]  alarm_hours,
    input  logic [5:0]  alarm_minutes,
    input  logic        alarm_ack,
    output logic [5:0]  seconds,
    output logic [5:0]  minutes,
    output logic [4:0]  hours,
    output logic        pm,
    output logic        sec_tick,
    output logic        day_tick,
    output logic        set_err,
    output logic        alarm
);

    rtc_time_t         cur_q;
    rtc_time_t         cur_inc;
    logic [HOUR_W-1:0] alarm_h_q;
    logic [MIN_W-1:0]  alarm_m_q;
    logic              armed_q;
    logic              alarm_q;
    logic              sec_tick_q;
    logic              day_tick_q;
    logic              set_err_q;

    logic tick;
    logic set_ok;
    logic alarm_ok;
    logic load;
    logic advance;
    logic day_wrap;
    logic alarm_hit;

    assign set_ok   = time_valid(set_hours, set_minutes, set_seconds);
    assign alarm_ok = time_valid(alarm_hours, alarm_minutes, SEC_W'(0));
    assign load     = set_valid && set_ok;
    assign advance  = tick && !load;

    rtc_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (load),
        .tick(tick)
    );

    assign cur_inc  = time_inc(cur_q);
    assign day_wrap = (cur_inc == '0);
    // Only a tick-driven arrival at hh:mm:00 fires; loads never do.
    assign alarm_hit = armed_q
                    && (cur_inc.hour == alarm_h_q)
                    && (cur_inc.minute == alarm_m_q)
                    && (cur_inc.second == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q      <= '0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
        end else if (load) begin
            cur_q.hour   <= set_hours;
            cur_q.minute <= set_minutes;
            cur_q.second <= set_seconds;
            sec_tick_q   <= 1'b0;
            day_tick_q   <= 1'b0;
        end else if (advance) begin
            cur_q      <= cur_inc;
            sec_tick_q <= 1'b1;
            day_tick_q <= day_wrap;
        end else begin
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_h_q <= '0;
            alarm_m_q <= '0;
            armed_q   <= 1'b0;
        end else if (alarm_wr && alarm_ok) begin
            alarm_h_q <= alarm_hours;
            alarm_m_q <= alarm_minutes;
            armed_q   <= 1'b1;
        end
    end

    // Fire has priority over a same-cycle acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else if (advance && alarm_hit) begin
            alarm_q <= 1'b1;
        end else if (alarm_ack) begin
            alarm_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_err_q <= 1'b0;
        end else begin
            set_err_q <= (set_valid && !set_ok) || (alarm_wr && !alarm_ok);
        end
    end

    assign seconds  = cur_q.second;
    assign minutes  = cur_q.minute;
    assign hours    = display_hour(cur_q.hour, mode_12h);
    assign pm       = (cur_q.hour >= NOON);
    assign sec_tick = sec_tick_q;
    assign day_tick = day_tick_q;
    assign set_err  = set_err_q;
    assign alarm    = alarm_q;

endmodule
